pushbutton_conditioner: RTL and testbench
=========================================

Name: pushbutton_conditioner

Overview:
- Upstream input stage for the 4-bit microprocessor; drives its `pushbuttons` data input, which is sampled onto the data bus by the IN instruction.
- Per bit it provides: a 2-FF synchronizer for the asynchronous board buttons, a counter-based debouncer, and one-cycle press/release pulses.
- Optionally holds a press until the processor consumes it, so a short tap between two IN instructions is not lost.

Parameters:
- WIDTH, 4, number of button bits (matches the processor data bus).
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronized level must hold before it is accepted. Legal range 2..65535; elaboration fails outside it.
- CNT_W, clog2(DEBOUNCE_CYCLES), derived counter width. Not overridable.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately, release is sampled on the clock.
- btn_raw  in  WIDTH  raw, bouncing, asynchronous button levels (1 = pressed).
- consume  in  1  one-cycle strobe from the processor, asserted when an IN instruction reads `pushbuttons`.
- pushbuttons  out  WIDTH  conditioned button value to the processor.
- stable  out  WIDTH  debounced level per bit.
- press_pulse  out  WIDTH  one-cycle pulse when a bit's stable level goes 0->1.
- release_pulse  out  WIDTH  one-cycle pulse when a bit's stable level goes 1->0.
- any_pressed  out  1  OR of all `stable` bits.

Behaviour:
- Reset (reset=0), asynchronous:
  - sync1, sync2, stable, counters, press latch all 0.
  - press_pulse and release_pulse 0.
  - pushbuttons and any_pressed 0.
- Synchronizer: sync1 <= btn_raw, sync2 <= sync1. No logic between the two stages.
- Per-bit debounce state machine, states SETTLED and COUNTING:
  - SETTLED, sync2==stable: count held at 0.
  - SETTLED, sync2!=stable: go to COUNTING, count <= 1.
  - COUNTING, sync2==stable (bounce): go to SETTLED, count <= 0. No pulse.
  - COUNTING, sync2!=stable, count < DEBOUNCE_CYCLES-1: count++.
  - COUNTING, sync2!=stable, count == DEBOUNCE_CYCLES-1: stable <= sync2, count <= 0, go to SETTLED.
- Latency: a clean edge on btn_raw sampled at clock edge k appears on `stable` after edge k+1+DEBOUNCE_CYCLES.
- Pulses: registered at the same edge that `stable` updates, so they are high during the first cycle the new `stable` value is visible, for exactly one cycle.
- Press and release are mutually exclusive per bit.
- Bits are fully independent; simultaneous transitions on several bits give simultaneous pulses.
- Counter never wraps: its maximum is DEBOUNCE_CYCLES-1 and it is then cleared.
- A reset asserted mid-count discards the count and any pending latch. No pulse is generated on reset release.
- The block uses `consume` only in PB_STICKY_EN mode; otherwise it is ignored.

Optional Feature:
- Macro PB_STICKY_EN.
- Defined:
  - Per-bit press latch is set by press_pulse and cleared by consume.
  - If set and clear coincide, set wins, so a new press is never lost.
  - pushbuttons = stable | latch, so a press shorter than the processor's polling interval is reported once.
- Undefined:
  - No latch flops exist and consume is unused.
  - pushbuttons = stable.

Decomposition:
- Shared package pb_pkg:
  - DEFAULT_WIDTH=4 and DEFAULT_DEBOUNCE_CYCLES=16.
  - Enumerated debounce state type (SETTLED, COUNTING).
  - Function computing CNT_W.
- Sub-module pb_debounce_bit: one bit's synchronizer, counter, state machine and pulse generation.
  - Instantiated WIDTH times by a generate loop.
- Top level holds the optional latch, the output OR and any_pressed.

Test Plan:
1. Reset: drive btn_raw=4'b1111 and reset=0 mid-run -> all outputs 0 immediately (asynchronous), then stable=4'b1111 exactly 2+DEBOUNCE_CYCLES edges after reset=1, with one press_pulse per bit.
2. Clean press (DEBOUNCE_CYCLES=4): btn_raw[0] 0->1 before edge k -> stable[0]=1 and press_pulse[0]=1 after edge k+5, press_pulse[0]=0 after edge k+6; release gives release_pulse[0] with the same timing.
3. Bounce: btn_raw[2] toggles 1,0,1,0 every 2 cycles then holds 1 -> no pulse during bouncing; exactly one press_pulse[2], DEBOUNCE_CYCLES+2 edges after the last toggle.
4. Glitch shorter than the window: btn_raw[1]=1 for DEBOUNCE_CYCLES-1 cycles (post-sync) then 0 -> stable[1] stays 0, no pulses.
5. Sticky, PB_STICKY_EN defined: 2-cycle-stable tap on bit 3 released before consume -> pushbuttons=4'b1000 held; consume -> 4'b0000 next cycle; consume coincident with a new press_pulse[3] -> latch remains 1.
6. Non-sticky, macro undefined: same stimulus -> pushbuttons tracks stable exactly; consume has no effect.

Source files
------------

// File: rtl/pushbutton_conditioner_pkg.sv
// Shared defaults, debounce state type and counter-width helper for the
// pushbutton conditioner.
package pb_pkg;

    localparam int DEFAULT_WIDTH           = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    typedef enum logic [0:0] {
        SETTLED  = 1'b0,
        COUNTING = 1'b1
    } db_state_e;

    // Bits needed to hold 0..cycles-1, never less than one.
    function automatic int cnt_width(input int cycles);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < cycles) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/pushbutton_conditioner_if.sv
// Button-side bundle between the conditioner (slave) and its environment (master).
interface pushbutton_conditioner_if
    import pb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] btn_raw;
    logic             consume;
    logic [WIDTH-1:0] pushbuttons;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;
    logic             any_pressed;

    modport master (
        output btn_raw, consume,
        input  pushbuttons, stable, press_pulse, release_pulse, any_pressed
    );

    modport slave (
        input  btn_raw, consume,
        output pushbuttons, stable, press_pulse, release_pulse, any_pressed
    );

endinterface

// File: rtl/pb_debounce_bit.sv
// One button bit: 2-FF synchronizer, counting debouncer and registered
// press/release pulses.
module pb_debounce_bit
    import pb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw_i,
    output logic stable_o,
    output logic press_o,
    output logic release_o
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             press_q;
    logic             release_q;
    logic [CNT_W-1:0] cnt_q;
    db_state_e        state_q;

    // Synchronizer chain plus debounce FSM; pulses update with stable_q.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= SETTLED;
        end else begin
            sync1_q   <= btn_raw_i;
            sync2_q   <= sync1_q;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                SETTLED: begin
                    if (sync2_q != stable_q) begin
                        state_q <= COUNTING;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                COUNTING: begin
                    if (sync2_q == stable_q) begin
                        state_q <= SETTLED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        stable_q  <= sync2_q;
                        press_q   <= sync2_q;
                        release_q <= ~sync2_q;
                        cnt_q     <= '0;
                        state_q   <= SETTLED;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= SETTLED;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign stable_o  = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/pushbutton_conditioner.sv
// Conditions the processor's pushbutton input. Define PB_STICKY_EN to hold
// each press until the processor consumes it.
module pushbutton_conditioner
    import pb_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                     clock,
    input  logic                     reset,
    pushbutton_conditioner_if.slave  bus
);

    if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 65535)) begin : g_bad_cycles
        $error("pushbutton_conditioner: DEBOUNCE_CYCLES must be 2..65535");
    end

    logic [WIDTH-1:0] stable_s;
    logic [WIDTH-1:0] press_s;
    logic [WIDTH-1:0] release_s;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        pb_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clock     (clock),
            .reset     (reset),
            .btn_raw_i (bus.btn_raw[g]),
            .stable_o  (stable_s[g]),
            .press_o   (press_s[g]),
            .release_o (release_s[g])
        );
    end

`ifdef PB_STICKY_EN
    logic [WIDTH-1:0] latch_d;
    logic [WIDTH-1:0] latch_q;

    // A press pulse sets the latch even when consume clears it in the same cycle.
    always_comb begin
        latch_d = press_s | (latch_q & ~{WIDTH{bus.consume}});
    end

    // Press latch register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            latch_q <= '0;
        end else begin
            latch_q <= latch_d;
        end
    end

    assign bus.pushbuttons = stable_s | latch_q;
`else
    logic unused_consume_s;
    assign unused_consume_s = bus.consume;
    assign bus.pushbuttons  = stable_s;
`endif

    assign bus.stable        = stable_s;
    assign bus.press_pulse   = press_s;
    assign bus.release_pulse = release_s;
    assign bus.any_pressed   = |stable_s;

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Self-checking bench for pushbutton_conditioner (DEBOUNCE_CYCLES=4); works with
// or without PB_STICKY_EN.
module tb_pushbutton_conditioner;
    import pb_pkg::*;

    localparam int W = 4;
    localparam int D = 4;

    logic clock;
    logic reset;

    pushbutton_conditioner_if #(.WIDTH(W)) bus ();

    pushbutton_conditioner #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec;
    int n_miss;

    // Reference: stable flips once the last D synchronized samples all disagree with it.
    logic [W-1:0] hist [0:D+1];
    logic [W-1:0] m_stable, m_press, m_release, m_latch;

    typedef struct {
        logic [W-1:0] btn;
        logic         con;
        logic [W-1:0] stb;
        logic [W-1:0] prs;
        logic [W-1:0] rel;
    } vec_t;
    vec_t vtab [0:13];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i <= D + 1; i++) hist[i] = '0;
        m_stable  = '0;
        m_press   = '0;
        m_release = '0;
        m_latch   = '0;
    endtask

    task automatic model_edge(input logic [W-1:0] b, input logic c);
        logic [W-1:0] latch_n;
        bit           all_diff;
        latch_n = m_press | (m_latch & ~{W{c}});
`ifndef PB_STICKY_EN
        latch_n = '0;
`endif
        for (int i = D + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0]   = b;
        m_press   = '0;
        m_release = '0;
        for (int k = 0; k < W; k++) begin
            all_diff = 1'b1;
            for (int i = 2; i <= D + 1; i++) begin
                if (hist[i][k] == m_stable[k]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_press[k]   = ~m_stable[k];
                m_release[k] = m_stable[k];
                m_stable[k]  = ~m_stable[k];
            end
        end
        m_latch = latch_n;
    endtask

    task automatic model_compare();
        check("model_stable",  bus.stable,        m_stable);
        check("model_press",   bus.press_pulse,   m_press);
        check("model_release", bus.release_pulse, m_release);
        check("model_pb",      bus.pushbuttons,   m_stable | m_latch);
        check("model_any",     {3'b000, bus.any_pressed}, {3'b000, |m_stable});
    endtask

    task automatic step(input logic [W-1:0] b, input logic c);
        bus.btn_raw = b;
        bus.consume = c;
        @(posedge clock);
        model_edge(b, c);
        #1;
        model_compare();
    endtask

    logic [W-1:0] exp_pb;
    logic [W-1:0] cur;
    int           hold;
    int           cnt_a;
    int           cnt_b;

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        reset       = 1'b0;
        bus.btn_raw = '0;
        bus.consume = 1'b0;
        model_reset();

        // Reset state.
        #8;
        check("rst_stable",  bus.stable,        4'b0000);
        check("rst_press",   bus.press_pulse,   4'b0000);
        check("rst_release", bus.release_pulse, 4'b0000);
        check("rst_pb",      bus.pushbuttons,   4'b0000);
        check("rst_any",     {3'b000, bus.any_pressed}, 4'b0000);
        #2 reset = 1'b1;
        for (int i = 0; i < 8; i++) step(4'b0000, 1'b0);

        // Clean press and release of bit 0, one row per clock.
        for (int r = 0; r < 5; r++) vtab[r] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        vtab[5] = '{4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0000};
        vtab[6] = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000};
        vtab[7] = '{4'b0000, 1'b1, 4'b0001, 4'b0000, 4'b0000};
        for (int r = 8; r < 12; r++) vtab[r] = '{4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000};
        vtab[12] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0001};
        vtab[13] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        for (int r = 0; r < 14; r++) begin
            step(vtab[r].btn, vtab[r].con);
            check("tab_stable",  bus.stable,        vtab[r].stb);
            check("tab_press",   bus.press_pulse,   vtab[r].prs);
            check("tab_release", bus.release_pulse, vtab[r].rel);
            check("tab_pb",      bus.pushbuttons,   vtab[r].stb);
            check("tab_any",     {3'b000, bus.any_pressed}, {3'b000, |vtab[r].stb});
        end

        // Asynchronous reset mid-run, then recovery with all buttons held.
        for (int i = 0; i < D + 4; i++) step(4'b1111, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("arst_stable",  bus.stable,        4'b0000);
        check("arst_press",   bus.press_pulse,   4'b0000);
        check("arst_release", bus.release_pulse, 4'b0000);
        check("arst_pb",      bus.pushbuttons,   4'b0000);
        check("arst_any",     {3'b000, bus.any_pressed}, 4'b0000);
        model_reset();
        #2 reset = 1'b1;
        for (int i = 1; i <= D + 3; i++) begin
            step(4'b1111, 1'b0);
            if (i == D + 1) check("arst_early", bus.stable, 4'b0000);
            if (i == D + 2) begin
                check("arst_stable_up", bus.stable,      4'b1111);
                check("arst_press_up",  bus.press_pulse, 4'b1111);
            end
            if (i == D + 3) check("arst_press_once", bus.press_pulse, 4'b0000);
        end
        for (int i = 0; i < D + 4; i++) step(4'b0000, 1'b0);

        // Bounce on bit 2, then a held press.
        cnt_a = 0;
        for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < 2; j++) begin
                step((s % 2 == 0) ? 4'b0100 : 4'b0000, 1'b0);
                if (bus.press_pulse[2] || bus.release_pulse[2]) cnt_a++;
            end
        end
        check("bounce_quiet", 4'(cnt_a), 4'd0);
        cnt_a = 0;
        for (int i = 0; i < D + 4; i++) begin
            step(4'b0100, 1'b0);
            if (bus.press_pulse[2]) cnt_a++;
            if (i == D + 1) check("bounce_press_edge", bus.press_pulse, 4'b0100);
        end
        check("bounce_one_press", 4'(cnt_a), 4'd1);

        // Glitch on bit 1 one cycle shorter than the window.
        cnt_b = 0;
        for (int i = 0; i < D - 1; i++) begin
            step(4'b0110, 1'b0);
            if (bus.stable[1] || bus.press_pulse[1] || bus.release_pulse[1]) cnt_b++;
        end
        for (int i = 0; i < 2 * D; i++) begin
            step(4'b0100, 1'b0);
            if (bus.stable[1] || bus.press_pulse[1] || bus.release_pulse[1]) cnt_b++;
        end
        check("glitch_ignored", 4'(cnt_b), 4'd0);
        for (int i = 0; i < D + 4; i++) step(4'b0000, 1'b0);

        // Tap on bit 3 released before the processor reads it.
`ifdef PB_STICKY_EN
        exp_pb = 4'b1000;
`else
        exp_pb = 4'b0000;
`endif
        for (int i = 0; i < D + 2; i++) step(4'b1000, 1'b0);
        for (int i = 0; i < D + 4; i++) step(4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 1'b0);
            check("sticky_hold", bus.pushbuttons, exp_pb);
        end
        step(4'b0000, 1'b1);
        check("sticky_consumed", bus.pushbuttons, 4'b0000);

        // Consume coincident with a new press pulse: the press must survive.
        for (int i = 0; i < D + 2; i++) step(4'b1000, 1'b0);
        check("coinc_pulse", bus.press_pulse, 4'b1000);
        step(4'b1000, 1'b1);
        check("coinc_pb", bus.pushbuttons, 4'b1000);
        for (int i = 0; i < D + 5; i++) step(4'b0000, 1'b0);
        check("coinc_latched", bus.pushbuttons, exp_pb);
        step(4'b0000, 1'b1);
        check("coinc_consumed", bus.pushbuttons, 4'b0000);

        // Random stimulus against the reference model.
        hold = 0;
        cur  = '0;
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                cur  = 4'($urandom_range(0, 15));
                hold = $urandom_range(1, 2 * D + 2);
            end
            step(cur, ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
            hold--;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
